// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns single-cycle read/write requests into
// strobes for a synchronous RAM with configurable read latency.
module mem_access_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int MEM_DEPTH = 4096,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } state_e;

  // One extra bit so MEM_DEPTH = 2^ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [2:0]      LAT_C   = 3'(RD_LAT);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              err_pend_q, err_pend_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              addr_err_q, addr_err_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic              in_range;
  logic              free;

  assign in_range = ({1'b0, addr} < DEPTH_C);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_pend_d  = 1'b0;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    addr_err_d  = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    free        = 1'b0;

    // Completion of the access in flight; the completing edge may also accept.
    case (state_q)
      IDLE: begin
        free = 1'b1;
        if (err_pend_q) begin
          done_d     = 1'b1;
          addr_err_d = 1'b1;
          rdata_d    = '0;
        end
      end
      RD_WAIT: begin
        if (cnt_q == LAT_C) begin
          done_d  = 1'b1;
          rdata_d = ram_rdata;
          state_d = IDLE;
          free    = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
        free    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance: write wins a collision; out-of-range never touches the RAM.
    if (free && (rd_req || wr_req)) begin
      if (!in_range) begin
        err_pend_d = 1'b1;
      end else if (wr_req) begin
        state_d     = WR;
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = addr;
        ram_wdata_d = wdata;
      end else begin
        state_d    = RD_WAIT;
        cnt_d      = 3'd0;
        ram_en_d   = 1'b1;
        ram_addr_d = addr;
      end
    end

    busy_d = (state_d != IDLE) || err_pend_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      err_pend_q  <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_pend_q  <= err_pend_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, which sets the memory word width.
REQ-002 The module SHALL have parameter ADDR_W, default 12, which sets the address width and matches the address-register output.
REQ-003 The module SHALL have parameter MEM_DEPTH, default 4096, which is the number of valid words; legal range is 1..2^ADDR_W.
REQ-004 The module SHALL have parameter RD_LAT, default 2, which is the RAM read latency in cycles; legal range is 1..4.
REQ-005 The module SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port rstn, input, width 1, a synchronous active-low reset.
REQ-007 The module SHALL have port rd_req, input, width 1, a read request from the control unit.
REQ-008 The module SHALL have port wr_req, input, width 1, a write request from the control unit.
REQ-009 The module SHALL have port addr, input, width ADDR_W, the access address taken from the address register.
REQ-010 The module SHALL have port wdata, input, width DATA_W, the write data taken from the data register.
REQ-011 The module SHALL have port rdata, output, width DATA_W, the registered read result.
REQ-012 The module SHALL have port busy, output, width 1, which is high while an access is in flight.
REQ-013 The module SHALL have port done, output, width 1, a one-cycle completion pulse.
REQ-014 The module SHALL have port addr_err, output, width 1, which is high with done when the access was out of range.
REQ-015 The module SHALL have ports ram_en, ram_we, ram_addr[ADDR_W] and ram_wdata[DATA_W] as outputs, and port ram_rdata[DATA_W] as an input, forming the synchronous RAM port.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_WAIT and WR, and all outputs SHALL be registered.
REQ-017 In IDLE, requests SHALL be sampled on each edge; while busy=1, both rd_req and wr_req SHALL be ignored (not queued).
REQ-018 If rd_req and wr_req are both high in IDLE, the write SHALL win and the read SHALL be dropped with no flag.
REQ-019 An accepted request SHALL latch addr and wdata internally; later changes on addr or wdata SHALL have no effect on that access.
REQ-020 Range check: if addr >= MEM_DEPTH, then ram_en SHALL stay 0, the state SHALL stay IDLE, and on the next edge done=1, addr_err=1 and rdata=0.
REQ-021 Read timing: a read accepted at edge E0 SHALL drive ram_en=1, ram_we=0 and ram_addr for exactly one cycle (E0 to E1), then move to RD_WAIT.
REQ-022 RD_WAIT SHALL count cycles with an internal 3-bit counter; at edge E(1+RD_LAT), ram_rdata SHALL be captured into rdata, done SHALL pulse, and the state SHALL return to IDLE.
REQ-023 Write timing: a write accepted at E0 SHALL drive ram_en=1, ram_we=1, ram_addr and ram_wdata for exactly one cycle (E0 to E1); at E1 done SHALL pulse and the state SHALL return to IDLE.
REQ-024 busy SHALL be 1 from the accepting edge until the edge that raises done; busy SHALL be 0 in the done cycle, so a new request may be accepted in that cycle.
REQ-025 done and addr_err SHALL each be high for exactly one cycle per completed access.
REQ-026 rdata SHALL change only on read completion, on an addr_err completion, or on reset; writes SHALL leave rdata unchanged.
REQ-027 Outside their drive cycle, ram_en and ram_we SHALL be 0; ram_addr and ram_wdata SHALL hold their last value.
REQ-028 Back-to-back accesses SHALL be allowed: a request sampled in a done cycle SHALL start the next access with no idle gap.

Reset
REQ-029 While rstn=0 at a clock edge, the module SHALL set state=IDLE, rdata=0, busy=0, done=0, addr_err=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0 and counter=0.
REQ-030 A reset during RD_WAIT or WR SHALL abort the access with no done pulse, and the RAM strobes SHALL be 0 from that edge onward.
REQ-031 Requests SHALL be ignored on any edge where rstn=0; the first accepted request SHALL be on the first edge with rstn=1.

Verification
REQ-032 Read: preload RAM[0x005]=0xBEEF, RD_LAT=2, pulse rd_req with addr=0x005 at E0 -> ram_en=1 in cycle E0-E1 only; at E3 done=1, rdata=0xBEEF; busy=1 from E0 to E2.
REQ-033 Write then read: wr_req with addr=0x7FF and wdata=0x1234 at E0 -> ram_we=1 in one cycle, done at E1; rd_req of 0x7FF at E1 -> rdata=0x1234 at E4.
REQ-034 Collision and ignore: rd_req and wr_req together (addr=0x010, wdata=0x00AA) -> write only; a rd_req asserted while busy=1 -> no extra ram_en and no extra done.
REQ-035 Range: MEM_DEPTH=2048, rd_req with addr=0x800 -> ram_en never asserted; next edge done=1, addr_err=1, rdata=0x0000.
REQ-036 Reset mid-read: drive rstn=0 one cycle after a read is accepted -> no done pulse; all outputs at reset values; a read issued after rstn=1 completes normally.
REQ-037 Latency sweep: run the REQ-032 read with RD_LAT set to 1 and to 4 -> done at E2 and at E5 respectively.
